imem_read_arbiter: RTL

IMEM_READ_ARBITER -- requirements
Module: imem_read_arbiter

---
 rtl/imem_read_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imem_read_arbiter.sv
// Two-requester read arbiter for the instruction-memory AXI read port.
// Define IMEM_ARB_RR_EN to alternate grants on simultaneous requests.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module imem_read_arbiter #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_rlast,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_rlast,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [3:0]        s_arid,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [3:0]        s_rid,
  input  logic              s_rvalid,
  input  logic              s_rlast,
  output logic              s_rready,
  output logic              busy,
  output logic              grant
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              win;
  logic              any_req;
  logic              hit;
  logic              done;
  logic [LEN_W-1:0]  len_eff;
  logic [LEN_W-1:0]  cnt_inc;

  assign any_req = m0_arvalid | m1_arvalid;

`ifdef IMEM_ARB_RR_EN
  // Resets to 1 so the first tie after reset goes to m0.
  logic rr_last_q, rr_last_d;

  always_comb begin
    win = ~m0_arvalid;
    if (m0_arvalid && m1_arvalid) win = ~rr_last_q;
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == IDLE && any_req) rr_last_d = win;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
`else
  assign win = ~m0_arvalid;
`endif

  assign len_eff = (len_q == '0) ? LEN_W'(1) : len_q;
  assign cnt_inc = cnt_q + LEN_W'(1);
  assign hit     = (state_q == DATA) && s_rvalid &&
                   (s_rid == {3'b000, grant_q});
  assign done    = hit && ((cnt_inc == len_eff) || s_rlast);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = win;
          addr_d  = win ? m1_araddr : m0_araddr;
          len_d   = win ? m1_arlen : m0_arlen;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (s_arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (done)     state_d = IDLE;
        else if (hit) cnt_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign s_arvalid = (state_q == ADDR);
  assign s_araddr  = addr_q;
  assign s_arlen   = len_q;
  assign s_arid    = {3'b000, grant_q};
  assign s_rready  = 1'b1;

  assign m0_arready = s_arvalid && s_arready && !grant_q;
  assign m1_arready = s_arvalid && s_arready && grant_q;

  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rvalid = hit && !grant_q;
  assign m1_rvalid = hit && grant_q;
  assign m0_rlast  = done && !grant_q;
  assign m1_rlast  = done && grant_q;

  assign busy  = (state_q != IDLE);
  assign grant = grant_q;

endmodule
